hazard_ctrl: RTL and testbench

- Central pipeline hazard and interrupt sequencer.
- Produces the stall and flush controls consumed by the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards, control redirects from EX (taken branch, call, returni) and data-memory wait states.
- Sequences interrupt entry by draining the pipeline, then injecting the interrupt flag into ID/EX.

---
 rtl/hazard_ctrl.sv | 106 ++++++++++
 tb/tb_hazard_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencer for load-use, EX redirects, memory waits and interrupt entry.
// Ports: clk, rst_n (async active-low); ID source regs/uses; EX dest/write/load/redirect/returni;
//   mem_busy freezes the pipeline; int_req is a level request.
// Outputs: pc/if_id/id_ex/ex_mem stalls, if_id/id_ex flushes, int_inject, int_ack, in_isr.
// Optional: define HAZARD_PERF_CNT_EN to add the saturating perf_stall_cnt/perf_flush_cnt outputs.
module hazard_ctrl #(
   parameter int REG_ADDR_W      = 4,
   parameter int LOAD_USE_STALLS = 1,
   parameter int DRAIN_CYCLES    = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] ex_reg_dst,
   input  logic                  ex_reg_wr,
   input  logic                  ex_wb_sel,
   input  logic                  ex_redirect,
   input  logic                  ex_returni,
   input  logic                  mem_busy,
   input  logic                  int_req,
   output logic                  pc_stall,
   output logic                  if_id_stall,
   output logic                  if_id_flush,
   output logic                  id_ex_stall,
   output logic                  id_ex_flush,
   output logic                  ex_mem_stall,
   output logic                  int_inject,
   output logic                  int_ack,
   output logic                  in_isr
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]           perf_stall_cnt,
   output logic [31:0]           perf_flush_cnt
`endif
);
   typedef enum logic [1:0] {RUN, DRAIN, INJECT, ISR} state_t;
   state_t     state, state_nxt;
   logic [1:0] bub, bub_nxt;
   logic [2:0] drn, drn_nxt;
   logic       lu_hit, redir, lu, drain, inj;
   assign lu_hit = ex_wb_sel & ex_reg_wr &
                   ((id_use_rs1 & (id_rs1 == ex_reg_dst)) | (id_use_rs2 & (id_rs2 == ex_reg_dst)));
   // INJECT owns the ID/EX load for its single cycle; EX is a drained bubble then anyway.
   assign redir  = !mem_busy & ex_redirect & (state != INJECT);
   assign lu     = !mem_busy & !redir & (state != INJECT) & (lu_hit | (bub != 2'd0));
   assign drain  = !mem_busy & !redir & (state == DRAIN);
   assign inj    = !mem_busy & (state == INJECT);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         bub   <= '0;
         drn   <= '0;
      end else begin
         state <= state_nxt;
         bub   <= bub_nxt;
         drn   <= drn_nxt;
      end
   end
   always_comb begin
      state_nxt = state;
      bub_nxt   = bub;
      drn_nxt   = drn;
      if (!mem_busy) begin
         bub_nxt = redir ? 2'd0 :
                   (bub != 2'd0) ? bub - 2'd1 :
                   (lu && LOAD_USE_STALLS > 1) ? 2'(LOAD_USE_STALLS - 1) : 2'd0;
         case (state)
            RUN: if (int_req) begin
               state_nxt = DRAIN;
               drn_nxt   = 3'(DRAIN_CYCLES);
            end
            DRAIN: begin
               drn_nxt   = drn - 3'd1;
               state_nxt = (drn == 3'd1) ? INJECT : DRAIN;
            end
            INJECT: state_nxt = ISR;
            ISR: state_nxt = ex_returni ? RUN : ISR;
         endcase
      end
   end
   always_comb begin
      pc_stall     = mem_busy | lu | drain;
      if_id_stall  = mem_busy | lu | drain;
      id_ex_stall  = mem_busy;
      ex_mem_stall = mem_busy;
      if_id_flush  = redir | inj;
      id_ex_flush  = redir | lu | drain;
      int_inject   = inj;
      int_ack      = inj;
      in_isr       = (state == ISR);
   end
`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         perf_stall_cnt <= perf_stall_cnt + {31'd0, pc_stall & ~&perf_stall_cnt};
         perf_flush_cnt <= perf_flush_cnt + {31'd0, redir & ~&perf_flush_cnt};
      end
   end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with default parameters.
module tb_hazard_ctrl;
   typedef struct packed {
      logic [3:0] rs1, rs2;
      logic       u1, u2;
      logic [3:0] dst;
      logic       wr, wb, rd, ri, mb, ir;
   } stim_t;
   // Expected output vector: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, int_inject, int_ack, in_isr}
   localparam logic [8:0] E0   = 9'b000000000;
   localparam logic [8:0] ELU  = 9'b110010000;
   localparam logic [8:0] ERD  = 9'b001010000;
   localparam logic [8:0] EBZ  = 9'b110101000;
   localparam logic [8:0] EINJ = 9'b001000110;
   localparam logic [8:0] EISR = 9'b000000001;
   logic clk, rst_n;
   logic [3:0] id_rs1, id_rs2, ex_reg_dst;
   logic id_use_rs1, id_use_rs2, ex_reg_wr, ex_wb_sel, ex_redirect, ex_returni, mem_busy, int_req;
   logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, int_inject, int_ack, in_isr;
   logic [8:0] outs, exp_v;
   logic [8:0] exp_q[$];
   int checks = 0;
   int failures = 0;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
   hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_reg_dst(ex_reg_dst), .ex_reg_wr(ex_reg_wr), .ex_wb_sel(ex_wb_sel),
      .ex_redirect(ex_redirect), .ex_returni(ex_returni), .mem_busy(mem_busy), .int_req(int_req),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
      .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
      .int_inject(int_inject), .int_ack(int_ack), .in_isr(in_isr)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
   );
   assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, int_inject, int_ack, in_isr};
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic stim_t st(input logic [3:0] rs1, rs2, input logic u1, u2, input logic [3:0] dst,
                                input logic wr, wb, rd, ri, mb, ir);
      st = {rs1, rs2, u1, u2, dst, wr, wb, rd, ri, mb, ir};
   endfunction
   task automatic drive(input stim_t s, input logic [8:0] e);
      @(negedge clk);
      {id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_reg_dst, ex_reg_wr, ex_wb_sel,
       ex_redirect, ex_returni, mem_busy, int_req} = s;
      exp_q.push_back(e);
      #2;
   endtask
   stim_t Z, LU, IRQ;
   task automatic test_reset();
      rst_n = 1'b0;
      drive(Z, E0);
      exp_v = exp_q.pop_front(); checks++;
      if (outs !== exp_v) begin failures++; $display("FAIL reset_held got=%b exp=%b", outs, exp_v); end
      @(negedge clk); rst_n = 1'b1;
      drive(Z, E0);
      exp_v = exp_q.pop_front(); checks++;
      if (outs !== exp_v) begin failures++; $display("FAIL reset_release got=%b exp=%b", outs, exp_v); end
   endtask
   task automatic test_load_use();
      stim_t s[6]; logic [8:0] e[6];
      s[0] = LU;                                e[0] = ELU;
      s[1] = Z;                                 e[1] = E0;
      s[2] = st(5, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0); e[2] = E0;
      s[3] = st(0, 5, 0, 1, 5, 1, 0, 0, 0, 0, 0); e[3] = E0;
      s[4] = st(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0); e[4] = ELU;
      s[5] = st(7, 0, 1, 0, 7, 0, 1, 0, 0, 0, 0); e[5] = E0;
      for (int i = 0; i < 6; i++) begin
         drive(s[i], e[i]);
         exp_v = exp_q.pop_front(); checks++;
         if (outs !== exp_v) begin failures++; $display("FAIL load_use[%0d] got=%b exp=%b", i, outs, exp_v); end
      end
   endtask
   task automatic test_redirect();
      stim_t s[3]; logic [8:0] e[3];
      s[0] = LU; s[0].rd = 1'b1;                e[0] = ERD;
      s[1] = Z;                                 e[1] = E0;
      s[2] = st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); e[2] = ERD;
      for (int i = 0; i < 3; i++) begin
         drive(s[i], e[i]);
         exp_v = exp_q.pop_front(); checks++;
         if (outs !== exp_v) begin failures++; $display("FAIL redirect[%0d] got=%b exp=%b", i, outs, exp_v); end
      end
   endtask
   task automatic test_mem_freeze();
      stim_t s[7]; logic [8:0] e[7];
      for (int i = 0; i < 4; i++) begin s[i] = st(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0); e[i] = EBZ; end
      s[4] = st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); e[4] = ERD;
      s[5] = LU; s[5].mb = 1'b1;                e[5] = EBZ;
      s[6] = Z;                                 e[6] = E0;
      for (int i = 0; i < 7; i++) begin
         drive(s[i], e[i]);
         exp_v = exp_q.pop_front(); checks++;
         if (outs !== exp_v) begin failures++; $display("FAIL mem_freeze[%0d] got=%b exp=%b", i, outs, exp_v); end
      end
   endtask
   task automatic test_interrupt();
      stim_t s[9]; logic [8:0] e[9];
      s[0] = IRQ; e[0] = E0;
      for (int i = 1; i < 4; i++) begin s[i] = Z; e[i] = ELU; end
      s[4] = Z;   e[4] = EINJ;
      s[5] = Z;   e[5] = EISR;
      s[6] = IRQ; e[6] = EISR;
      s[7] = LU;  e[7] = ELU | EISR;
      s[8] = IRQ; e[8] = EISR;
      for (int i = 0; i < 9; i++) begin
         drive(s[i], e[i]);
         exp_v = exp_q.pop_front(); checks++;
         if (outs !== exp_v) begin failures++; $display("FAIL interrupt[%0d] got=%b exp=%b", i, outs, exp_v); end
      end
   endtask
   task automatic test_return();
      stim_t s[10]; logic [8:0] e[10];
      s[0] = IRQ; s[0].ri = 1'b1;               e[0] = EISR;
      s[1] = IRQ;                               e[1] = E0;
      s[2] = Z;                                 e[2] = ELU;
      s[3] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); e[3] = EBZ;
      s[4] = st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); e[4] = ERD;
      s[5] = Z;                                 e[5] = ELU;
      s[6] = Z;                                 e[6] = EINJ;
      s[7] = Z;                                 e[7] = EISR;
      s[8] = st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); e[8] = EISR;
      s[9] = Z;                                 e[9] = E0;
      for (int i = 0; i < 10; i++) begin
         drive(s[i], e[i]);
         exp_v = exp_q.pop_front(); checks++;
         if (outs !== exp_v) begin failures++; $display("FAIL return[%0d] got=%b exp=%b", i, outs, exp_v); end
      end
   endtask
   task automatic test_reset_mid_drain();
      stim_t s[3]; logic [8:0] e[3];
      s[0] = IRQ; e[0] = E0;
      s[1] = Z;   e[1] = ELU;
      s[2] = Z;   e[2] = ELU;
      for (int i = 0; i < 3; i++) begin
         drive(s[i], e[i]);
         exp_v = exp_q.pop_front(); checks++;
         if (outs !== exp_v) begin failures++; $display("FAIL mid_drain[%0d] got=%b exp=%b", i, outs, exp_v); end
      end
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.push_back(E0);
      #2;
      exp_v = exp_q.pop_front(); checks++;
      if (outs !== exp_v) begin failures++; $display("FAIL mid_drain_reset got=%b exp=%b", outs, exp_v); end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
         failures++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_stall_cnt, perf_flush_cnt);
      end
`endif
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(Z, E0);
         exp_v = exp_q.pop_front(); checks++;
         if (outs !== exp_v) begin failures++; $display("FAIL after_reset[%0d] got=%b exp=%b", i, outs, exp_v); end
      end
   endtask
   initial begin
      Z   = '0;
      LU  = st(0, 5, 0, 1, 5, 1, 1, 0, 0, 0, 0);
      IRQ = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      {id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_reg_dst, ex_reg_wr, ex_wb_sel,
       ex_redirect, ex_returni, mem_busy, int_req} = '0;
      rst_n = 1'b0;
      test_reset();
      test_load_use();
      test_redirect();
      test_mem_freeze();
      test_interrupt();
      test_return();
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
